// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
// State encoding, channel identifiers and the default audio word width.
package i2s_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    SHIFT     = 2'd1,
    HOLD      = 2'd2
  } i2s_rx_state_t;

  localparam logic I2S_LEFT   = 1'b0;
  localparam logic I2S_RIGHT  = 1'b1;
  localparam int   I2S_DATA_W = 24;

endpackage

// File: rtl/i2s_sync.sv
// N-stage synchronizer for one asynchronous input; resets to 0.
// Latency N clk cycles; no backpressure (free-running).
module i2s_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_d};
    end
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S deserializer: oversamples BCLK/LRCLK/SDATA in clk and emits left+right word pairs.
// Outputs update SYNC_STAGES clk edges after the sampling BCLK edge is first captured; no backpressure.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter bit SAMPLE_FALL = 1'b1
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              I2S_BCLK,
  input  logic              I2S_LRCLK,
  input  logic              I2S_SDATA,
  output logic [DATA_W-1:0] Ldata,
  output logic [DATA_W-1:0] Rdata,
  output logic              data_valid,
  output logic              short_err
);

  localparam int               SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic w_bclk_s;
  logic w_lr_s;
  logic w_sd_s;

  i2s_sync #(.N(SYNC_N)) u_sync_bclk (
    .i_clk   (clk),
    .i_rst_n (RSTn),
    .i_d     (I2S_BCLK),
    .o_q     (w_bclk_s)
  );

  i2s_sync #(.N(SYNC_N)) u_sync_lr (
    .i_clk   (clk),
    .i_rst_n (RSTn),
    .i_d     (I2S_LRCLK),
    .o_q     (w_lr_s)
  );

  i2s_sync #(.N(SYNC_N)) u_sync_sd (
    .i_clk   (clk),
    .i_rst_n (RSTn),
    .i_d     (I2S_SDATA),
    .o_q     (w_sd_s)
  );

  i2s_rx_state_t     r_state;
  logic              r_bclk_d;
  logic              r_primed;
  logic              r_lr_prev;
  logic              r_chan;
  logic              r_l_ok;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_l_hold;

  logic              w_bit_stb;
  logic              w_lr_chg;
  logic [DATA_W-1:0] w_word;

  assign w_bit_stb = SAMPLE_FALL ? (r_bclk_d & ~w_bclk_s) : (~r_bclk_d & w_bclk_s);
  // The first strobe after reset only seeds lr_prev, so a pin that is already
  // high at release is not mistaken for a word boundary.
  assign w_lr_chg  = r_primed & (w_lr_s != r_lr_prev);
  assign w_word    = {r_shreg[DATA_W-2:0], w_sd_s};

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= WAIT_EDGE;
      r_bclk_d   <= 1'b0;
      r_primed   <= 1'b0;
      r_lr_prev  <= 1'b0;
      r_chan     <= I2S_LEFT;
      r_l_ok     <= 1'b0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_l_hold   <= '0;
      Ldata      <= '0;
      Rdata      <= '0;
      data_valid <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      short_err  <= 1'b0;
      r_bclk_d   <= w_bclk_s;
      if (w_bit_stb) begin
        r_primed  <= 1'b1;
        r_lr_prev <= w_lr_s;
        case (r_state)
          WAIT_EDGE: begin
            if (w_lr_chg) begin
              r_state   <= SHIFT;
              r_bit_cnt <= '0;
              r_chan    <= w_lr_s;
            end
          end
          SHIFT: begin
            if (w_lr_chg) begin
              // Word cut short: this strobe becomes the delay slot of the new channel.
              short_err <= 1'b1;
              r_l_ok    <= 1'b0;
              r_bit_cnt <= '0;
              r_chan    <= w_lr_s;
            end else begin
              r_shreg <= w_word;
              if (r_bit_cnt < CNT_FULL) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
              if (r_bit_cnt == CNT_LAST) begin
                r_state <= HOLD;
                if (r_chan == I2S_LEFT) begin
                  r_l_hold <= w_word;
                  r_l_ok   <= 1'b1;
                end else if (r_l_ok) begin
                  Ldata      <= r_l_hold;
                  Rdata      <= w_word;
                  data_valid <= 1'b1;
                  r_l_ok     <= 1'b0;
                end
              end
            end
          end
          HOLD: begin
            if (w_lr_chg) begin
              r_state   <= SHIFT;
              r_bit_cnt <= '0;
              r_chan    <= w_lr_s;
            end
          end
          default: r_state <= WAIT_EDGE;
        endcase
      end
    end
  end

endmodule
